// File: rtl/cfg_reg_pkg.sv
// Shared constants, helpers and state types for the configuration register bank.
// Widths here bound the multi-byte write and read-back counters.
package cfg_reg_pkg;

  localparam int BYTES_MAX = 4;
  localparam int LEN_W     = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int CNT_W = clog2(BYTES_MAX + 1);
  localparam int TMR_W = clog2(65536);

  typedef enum logic {
    RD_EMPTY,
    RD_PENDING
  } rd_state_t;

endpackage

// File: rtl/cfg_reg_chan.sv
// One register channel: byte-wise staged write with gap timeout, committed value,
// and a shadow copy that is popped out MSB byte first for read-back.
module cfg_reg_chan
  import cfg_reg_pkg::*;
#(
  parameter int              REG_W      = 8,
  parameter logic [REG_W-1:0] RST_VAL_CH = '0,
  parameter int              TIMEOUT    = 255,
  parameter bit              ECHO       = 1'b1
) (
  input  logic             n_rst,
  input  logic             clk,
  input  logic [7:0]       master_data,
  input  logic             valid,
  input  logic             rdreq,
  output logic             have_msg,
  output logic [7:0]       slave_data,
  output logic [LEN_W-1:0] len,
  output logic [REG_W-1:0] reg_val
);

  localparam int BYTES = REG_W / 8;

  logic [REG_W-1:0] staging;
  logic [CNT_W-1:0] wr_cnt;
  logic [TMR_W-1:0] gap;
  logic [REG_W-1:0] next_val;
  logic             commit;
  logic             timed_out;

  // Incoming byte lands in the LSB so the first byte ends up as the MSB.
  assign next_val  = REG_W'({staging, master_data});
  assign commit    = valid && (wr_cnt == CNT_W'(BYTES - 1));
  assign timed_out = !valid && (wr_cnt != '0) && (gap == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      staging <= '0;
      wr_cnt  <= '0;
      gap     <= '0;
      reg_val <= RST_VAL_CH;
    end else if (valid) begin
      gap <= '0;
      if (commit) begin
        reg_val <= next_val;
        staging <= '0;
        wr_cnt  <= '0;
      end else begin
        staging <= next_val;
        wr_cnt  <= wr_cnt + CNT_W'(1);
      end
    end else if (timed_out) begin
      staging <= '0;
      wr_cnt  <= '0;
      gap     <= '0;
    end else if (wr_cnt != '0) begin
      gap <= gap + TMR_W'(1);
    end
  end

  rd_state_t        rd_state, rd_next;
  logic [REG_W-1:0] shadow, shadow_next;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_next;

  // A commit reloads the read-back and takes priority over a pop in the same cycle.
  always_comb begin
    rd_next     = rd_state;
    shadow_next = shadow;
    rd_cnt_next = rd_cnt;
    if (commit) begin
      rd_next     = RD_PENDING;
      shadow_next = next_val;
      rd_cnt_next = CNT_W'(BYTES);
    end else if (rdreq && rd_state == RD_PENDING) begin
      shadow_next = shadow << 8;
      rd_cnt_next = rd_cnt - CNT_W'(1);
      if (rd_cnt == CNT_W'(1)) rd_next = RD_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_state <= RD_EMPTY;
      shadow   <= '0;
      rd_cnt   <= '0;
    end else begin
      rd_state <= rd_next;
      shadow   <= shadow_next;
      rd_cnt   <= rd_cnt_next;
    end
  end

  generate
    if (ECHO) begin : g_echo
      assign have_msg   = (rd_state == RD_PENDING);
      assign slave_data = shadow[REG_W-1 -: 8];
      assign len        = LEN_W'(rd_cnt);
    end else begin : g_no_echo
      assign have_msg   = 1'b0;
      assign slave_data = '0;
      assign len        = '0;
    end
  endgenerate

endmodule

// File: rtl/cfg_reg_bank.sv
// Bank of N_CH byte-written control registers with per-channel read-back.
// Only instantiates channels and packs their ports onto the shared buses.
module cfg_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int                    N_CH    = 10,
  parameter int                    REG_W   = 8,
  parameter logic [N_CH*REG_W-1:0] RST_VAL = '0,
  parameter int                    TIMEOUT = 255,
  parameter bit                    ECHO    = 1'b1
) (
  input  logic                  n_rst,
  input  logic                  clk,
  input  logic [7:0]            master_data,
  input  logic [N_CH-1:0]       valid_bus,
  input  logic [N_CH-1:0]       rdreq_bus,
  output logic [N_CH-1:0]       have_msg_bus,
  output logic [N_CH*8-1:0]     slave_data_bus,
  output logic [N_CH*LEN_W-1:0] len_bus,
  output logic [N_CH*REG_W-1:0] reg_out
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      cfg_reg_chan #(
        .REG_W      (REG_W),
        .RST_VAL_CH (RST_VAL[i*REG_W +: REG_W]),
        .TIMEOUT    (TIMEOUT),
        .ECHO       (ECHO)
      ) u_chan (
        .n_rst       (n_rst),
        .clk         (clk),
        .master_data (master_data),
        .valid       (valid_bus[i]),
        .rdreq       (rdreq_bus[i]),
        .have_msg    (have_msg_bus[i]),
        .slave_data  (slave_data_bus[i*8 +: 8]),
        .len         (len_bus[i*LEN_W +: LEN_W]),
        .reg_val     (reg_out[i*REG_W +: REG_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Bench for cfg_reg_bank: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of committed values and read-back bytes.
module tb_cfg_reg_bank;

  localparam int N_CH    = 10;
  localparam int REG_W   = 16;
  localparam int BYTES   = REG_W / 8;
  localparam int TIMEOUT = 20;
  localparam logic [N_CH*REG_W-1:0] RST_VAL =
    (N_CH*REG_W)'(16'hA5C3) | ((N_CH*REG_W)'(16'h1F2E) << (5*REG_W));

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic [7:0]            master_data;
  logic [N_CH-1:0]       valid_bus, rdreq_bus, have_msg_bus;
  logic [N_CH*8-1:0]     slave_data_bus, len_bus;
  logic [N_CH*REG_W-1:0] reg_out;

  cfg_reg_bank #(
    .N_CH(N_CH), .REG_W(REG_W), .RST_VAL(RST_VAL), .TIMEOUT(TIMEOUT), .ECHO(1'b1)
  ) dut (
    .n_rst(n_rst), .clk(clk), .master_data(master_data), .valid_bus(valid_bus),
    .rdreq_bus(rdreq_bus), .have_msg_bus(have_msg_bus), .slave_data_bus(slave_data_bus),
    .len_bus(len_bus), .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [REG_W-1:0] m_reg   [N_CH];
  logic [7:0]       m_stage [N_CH][$];
  logic [7:0]       m_rd    [N_CH][$];
  int               m_idle  [N_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [REG_W-1:0] reg_of(input int ch);
    return reg_out[ch*REG_W +: REG_W];
  endfunction

  function automatic logic [7:0] sd_of(input int ch);
    return slave_data_bus[ch*8 +: 8];
  endfunction

  function automatic logic [7:0] len_of(input int ch);
    return len_bus[ch*8 +: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_reg[i] = RST_VAL[i*REG_W +: REG_W];
      m_stage[i].delete();
      m_rd[i].delete();
      m_idle[i] = 0;
    end
  endtask

  task automatic model_clock(input logic [N_CH-1:0] v, input logic [N_CH-1:0] r,
                             input logic [7:0] d);
    logic [REG_W-1:0] val;
    bit commit;
    for (int i = 0; i < N_CH; i++) begin
      commit = 1'b0;
      val = '0;
      if (v[i]) begin
        m_stage[i].push_back(d);
        m_idle[i] = 0;
        if (m_stage[i].size() == BYTES) begin
          foreach (m_stage[i][b]) val = (val << 8) | REG_W'(m_stage[i][b]);
          m_reg[i] = val;
          m_stage[i].delete();
          commit = 1'b1;
        end
      end else if (m_stage[i].size() != 0) begin
        m_idle[i]++;
        if (m_idle[i] == TIMEOUT) begin
          m_stage[i].delete();
          m_idle[i] = 0;
        end
      end
      if (commit) begin
        m_rd[i].delete();
        for (int b = BYTES - 1; b >= 0; b--) m_rd[i].push_back(val[b*8 +: 8]);
      end else if (r[i] && m_rd[i].size() != 0) begin
        void'(m_rd[i].pop_front());
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N_CH; i++) begin
      chk($sformatf("ch%0d.reg", i), 32'(reg_of(i)), 32'(m_reg[i]));
      chk($sformatf("ch%0d.have_msg", i), 32'(have_msg_bus[i]), 32'(m_rd[i].size() != 0));
      chk($sformatf("ch%0d.len", i), 32'(len_of(i)), 32'(m_rd[i].size()));
      chk($sformatf("ch%0d.slave_data", i), 32'(sd_of(i)),
          (m_rd[i].size() != 0) ? 32'(m_rd[i][0]) : 32'h0);
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks after the next rise.
  task automatic cycle(input logic [N_CH-1:0] v, input logic [N_CH-1:0] r, input logic [7:0] d);
    valid_bus   = v;
    rdreq_bus   = r;
    master_data = d;
    @(posedge clk);
    model_clock(v, r, d);
    @(negedge clk);
    valid_bus = '0;
    rdreq_bus = '0;
    check_all();
  endtask

  initial begin
    logic [N_CH-1:0] v, r;
    int dens;
    n_rst       = 1'b0;
    master_data = '0;
    valid_bus   = '0;
    rdreq_bus   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("t1_reg0", 32'(reg_of(0)), 32'hA5C3);
    chk("t1_have_msg", 32'(have_msg_bus), 32'h0);
    chk("t1_len", 32'(len_bus[31:0]), 32'h0);
    n_rst = 1'b1;

    cycle(10'h001, '0, 8'h12);
    chk("t2_partial_reg0", 32'(reg_of(0)), 32'hA5C3);
    cycle(10'h001, '0, 8'h34);
    chk("t2_reg0", 32'(reg_of(0)), 32'h1234);
    chk("t2_have", 32'(have_msg_bus[0]), 32'h1);
    chk("t2_len2", 32'(len_of(0)), 32'h2);
    chk("t2_sd12", 32'(sd_of(0)), 32'h12);
    cycle('0, 10'h001, 8'h00);
    chk("t2_sd34", 32'(sd_of(0)), 32'h34);
    chk("t2_len1", 32'(len_of(0)), 32'h1);
    cycle('0, 10'h001, 8'h00);
    chk("t2_empty", 32'(have_msg_bus[0]), 32'h0);
    chk("t2_sd0", 32'(sd_of(0)), 32'h0);

    cycle(10'h008, '0, 8'h55);
    repeat (TIMEOUT) cycle('0, '0, 8'h00);
    chk("t3_after_timeout", 32'(reg_of(3)), 32'h0);
    cycle(10'h008, '0, 8'h66);
    chk("t3_no_55xx", 32'(reg_of(3)), 32'h0);
    cycle(10'h008, '0, 8'h77);
    chk("t3_reg3", 32'(reg_of(3)), 32'h6677);

    cycle(10'h002, '0, 8'h12);
    cycle(10'h002, '0, 8'h34);
    cycle('0, 10'h002, 8'h00);
    cycle(10'h002, '0, 8'hAB);
    cycle(10'h002, '0, 8'hCD);
    chk("t4_len", 32'(len_of(1)), 32'h2);
    chk("t4_sd", 32'(sd_of(1)), 32'hAB);
    cycle('0, 10'h002, 8'h00);
    chk("t4_sd_cd", 32'(sd_of(1)), 32'hCD);

    cycle(10'h004, '0, 8'h9A);
    cycle(10'h004, 10'h004, 8'hBC);
    chk("t5_reg2", 32'(reg_of(2)), 32'h9ABC);
    chk("t5_len", 32'(len_of(2)), 32'(BYTES));
    chk("t5_sd", 32'(sd_of(2)), 32'h9A);

    cycle(10'h201, '0, 8'h0F);
    cycle(10'h201, '0, 8'h0F);
    chk("t6_reg0", 32'(reg_of(0)), 32'h0F0F);
    chk("t6_reg9", 32'(reg_of(9)), 32'h0F0F);
    cycle('0, 10'h001, 8'h00);
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_reg0", 32'(reg_of(0)), 32'hA5C3);
    chk("t6_rst_reg9", 32'(reg_of(9)), 32'h0);
    chk("t6_rst_have", 32'(have_msg_bus), 32'h0);
    chk("t6_rst_sd", 32'(slave_data_bus[79:0] != '0), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Dense traffic first, then sparse writes so gap timeouts occur.
    for (int k = 0; k < 1500; k++) begin
      dens = (k < 700) ? 2 : 40;
      for (int j = 0; j < N_CH; j++) begin
        v[j] = ($urandom_range(0, dens) == 0);
        r[j] = ($urandom_range(0, 2) == 0);
      end
      cycle(v, r, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
